fp_align_ctrl: RTL and testbench
================================

// Module: fp_align_ctrl
// PURPOSE
//  Sequencer for FP32 add/sub operand alignment.
//  - Accepts an operand pair; orders by magnitude; computes exponent difference.
//  - Drives the right barrel shifter to align the smaller mantissa; collects the sticky bit.
//  - Presents the aligned pair to the adder stage over a valid/ready handshake.
// PARAMETERS
//  EXP_W  8   exponent width
//  MAN_W  24  mantissa width incl. hidden bit
//  ALN_W  26  aligned width = MAN_W + guard + round
//  SHF_W  5   shifter control width; max shift 2**SHF_W-1 = 31
// PORTS
//  i_clk          in   1       clock, rising edge
//  i_rst          in   1       synchronous reset, active-high
//  i_valid        in   1       operand pair valid
//  o_ready        out  1       block can accept a pair
//  i_a, i_b       in   32      FP32 operands
//  o_valid        out  1       aligned result valid
//  i_ready        in   1       downstream accepts result
//  o_man_big      out  ALN_W   larger-magnitude mantissa, {man,2'b00}
//  o_man_small    out  ALN_W   smaller mantissa, right-aligned
//  o_exp          out  EXP_W   effective exponent of larger operand
//  o_sign_big     out  1       sign of larger operand
//  o_sign_small   out  1       sign of smaller operand
//  o_sticky       out  1       OR of bits shifted out of o_man_small
//  o_swap         out  1       1 when b is the larger operand
// BEHAVIOUR
//  FSM S_IDLE -> S_CMP -> S_SHIFT -> S_DONE -> S_IDLE. All state and outputs are registered.
//  - S_IDLE: o_ready=1. On i_valid, capture i_a/i_b and go to S_CMP.
//  - S_CMP: unpack each operand.
//    - hidden bit = |exp; effective exp = (exp==0) ? 1 : exp.
//    - swap when {exp_b,man_b} > {exp_a,man_a}; equal magnitudes do not swap.
//    - diff = exp_big - exp_small, unsigned, EXP_W bits.
//    - if diff > 2**SHF_W-1, shift = 2**SHF_W-1 and the saturation flag is set.
//  - S_SHIFT: shifter input = {man_small,2'b00}.
//    - Register shifter output; if the saturation flag is set, the result is forced to 0.
//    - Register sticky and all other outputs.
//  - S_DONE: o_valid=1, o_ready=0. Outputs held stable until i_valid... i.e. until i_ready=1.
//    - The transfer completes on the cycle i_ready=1; next state is S_IDLE.
//    - No new pair is accepted in that same cycle.
//  - Latency: accept at cycle N -> o_valid at N+3. Throughput: one pair per 4 cycles minimum.
//  - i_ready is ignored outside S_DONE. i_valid is ignored outside S_IDLE.
//  - NaN/Inf are not special-cased: fields pass through arithmetically. The adder stage handles them.
//  - Reset (any state, including mid-operation): state=S_IDLE, o_ready=1 from the first cycle after reset.
//    o_valid and all data outputs = 0.
// CONFIGURATION
//  FP_ALIGN_STICKY_EN
//  - Defined: o_sticky = OR of the shifted-out low bits of {man_small,2'b00}, computed in S_SHIFT.
//    On saturation, o_sticky = |man_small.
//  - Undefined: o_sticky is tied to 0 and the sticky mask logic is not built.
// STRUCTURE
//  Shared package fp_pkg:
//  - EXP_W, MAN_W, ALN_W, SHF_W constants.
//  - typedef fp32_t, a packed struct {sign, exp, frac}.
//  - typedef align_state_e for the FSM states.
//  Sub-module: one instance of the codebase's right barrel shifter SHF_right,
//  with SIZE_DATA=ALN_W and SIZE_SHIFT=SHF_W, driven from S_CMP registers.
//  Sticky mask: inline, ~({ALN_W{1'b1}} << shift) ANDed with the shifter input.
// TESTING
//  1. a=0x40000000, b=0x3F800000:
//     -> o_swap=0, o_exp=0x80, o_man_big=26'h2000000, o_man_small=26'h1000000, o_sticky=0; o_valid 3 cycles after accept.
//  2. a=0x3F800000, b=0x40800000:
//     -> o_swap=1, o_exp=0x81, o_man_big=26'h2000000, o_man_small=26'h0800000.
//  3. a=0x4B800000, b=0x3F800001 (diff 24):
//     -> o_man_small=26'h0000002, o_sticky=1 (0 without FP_ALIGN_STICKY_EN).
//  4. a=0x7F000000, b=0x3F800000 (diff 127, saturated):
//     -> o_man_small=0, o_sticky=1, o_exp=0xFE.
//  5. Back-pressure: hold i_ready=0 for 5 cycles in S_DONE
//     -> outputs unchanged, o_ready=0, i_valid ignored; i_ready=1 -> o_valid=0 and o_ready=1 next cycle.
//  6. Assert i_rst during S_SHIFT
//     -> next cycle o_valid=0, outputs 0, o_ready=1; the following pair aligns correctly.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FP32 alignment types and constants for the fp_align_ctrl slice.
package fp_pkg;

    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MAN_W   = 24;
    localparam int unsigned ALN_W   = 26;
    localparam int unsigned SHF_W   = 5;
    localparam int unsigned FRAC_W  = MAN_W - 1;
    localparam int unsigned SHF_MAX = (2 ** SHF_W) - 1;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  expo;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CMP   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } align_state_e;

    // Mantissa with hidden bit restored (denormals get a 0 hidden bit).
    function automatic logic [MAN_W-1:0] get_man(input fp32_t x);
        return {|x.expo, x.frac};
    endfunction

    // Denormals share the exponent of the smallest normal.
    function automatic logic [EXP_W-1:0] get_eff_exp(input fp32_t x);
        return (x.expo == '0) ? EXP_W'(1) : x.expo;
    endfunction

endpackage

// File: rtl/SHF_right.sv
// Logarithmic right barrel shifter, zero fill.
module SHF_right #(
    parameter int unsigned SIZE_DATA  = 26,
    parameter int unsigned SIZE_SHIFT = 5
) (
    input  logic [SIZE_DATA-1:0]  data_in,
    input  logic [SIZE_SHIFT-1:0] shift,
    output logic [SIZE_DATA-1:0]  data_out
);

    logic [SIZE_DATA-1:0] stage [SIZE_SHIFT+1];

    assign stage[0] = data_in;

    // Stage k shifts by 2**k when shift[k] is set.
    for (genvar k = 0; k < int'(SIZE_SHIFT); k++) begin : g_stage
        assign stage[k+1] = shift[k] ? (stage[k] >> (2 ** k)) : stage[k];
    end

    assign data_out = stage[SIZE_SHIFT];

endmodule

// File: rtl/fp_align_ctrl.sv
// FP32 add/sub operand alignment sequencer: order by magnitude, align smaller mantissa.
// Optional sticky collection enabled by defining FP_ALIGN_STICKY_EN.
module fp_align_ctrl
    import fp_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_a,
    input  logic [31:0]      i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [ALN_W-1:0] o_man_big,
    output logic [ALN_W-1:0] o_man_small,
    output logic [EXP_W-1:0] o_exp,
    output logic             o_sign_big,
    output logic             o_sign_small,
    output logic             o_sticky,
    output logic             o_swap
);

    align_state_e state, state_nxt;
    logic         ready_nxt, valid_nxt;
    logic         load_ops, load_cmp, load_out;

    fp32_t op_a, op_b;

    logic             swap_q, sign_big_q, sign_small_q, sat_q;
    logic [EXP_W-1:0] exp_big_q;
    logic [MAN_W-1:0] man_big_q, man_small_q;
    logic [SHF_W-1:0] shift_q;

    logic [MAN_W-1:0] man_a, man_b;
    logic [EXP_W-1:0] eexp_a, eexp_b, diff;
    logic             swap_c, sat_c;

    logic [ALN_W-1:0] shf_in, shf_out;

    // State register and registered handshake outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_IDLE;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
        end else begin
            state   <= state_nxt;
            o_ready <= ready_nxt;
            o_valid <= valid_nxt;
        end
    end

    // Next-state and per-state load strobes
    always_comb begin
        state_nxt = state;
        load_ops  = 1'b0;
        load_cmp  = 1'b0;
        load_out  = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_valid) begin
                    load_ops  = 1'b1;
                    state_nxt = S_CMP;
                end
            end
            S_CMP: begin
                load_cmp  = 1'b1;
                state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                load_out  = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                if (i_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        ready_nxt = (state_nxt == S_IDLE);
        valid_nxt = (state_nxt == S_DONE);
    end

    // Operand capture
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            op_a <= '0;
            op_b <= '0;
        end else if (load_ops) begin
            op_a <= fp32_t'(i_a);
            op_b <= fp32_t'(i_b);
        end
    end

    // Magnitude compare and exponent difference
    always_comb begin
        man_a  = get_man(op_a);
        man_b  = get_man(op_b);
        eexp_a = get_eff_exp(op_a);
        eexp_b = get_eff_exp(op_b);
        swap_c = {op_b.expo, man_b} > {op_a.expo, man_a};
        diff   = swap_c ? (eexp_b - eexp_a) : (eexp_a - eexp_b);
        sat_c  = diff > EXP_W'(SHF_MAX);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            swap_q       <= 1'b0;
            sign_big_q   <= 1'b0;
            sign_small_q <= 1'b0;
            sat_q        <= 1'b0;
            exp_big_q    <= '0;
            man_big_q    <= '0;
            man_small_q  <= '0;
            shift_q      <= '0;
        end else if (load_cmp) begin
            swap_q       <= swap_c;
            sign_big_q   <= swap_c ? op_b.sign : op_a.sign;
            sign_small_q <= swap_c ? op_a.sign : op_b.sign;
            sat_q        <= sat_c;
            exp_big_q    <= swap_c ? eexp_b : eexp_a;
            man_big_q    <= swap_c ? man_b : man_a;
            man_small_q  <= swap_c ? man_a : man_b;
            shift_q      <= sat_c ? SHF_W'(SHF_MAX) : diff[SHF_W-1:0];
        end
    end

    assign shf_in = {man_small_q, 2'b00};

    SHF_right #(
        .SIZE_DATA  (ALN_W),
        .SIZE_SHIFT (SHF_W)
    ) u_shf (
        .data_in  (shf_in),
        .shift    (shift_q),
        .data_out (shf_out)
    );

    // Aligned result registers, held through back-pressure
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_man_big    <= '0;
            o_man_small  <= '0;
            o_exp        <= '0;
            o_sign_big   <= 1'b0;
            o_sign_small <= 1'b0;
            o_swap       <= 1'b0;
        end else if (load_out) begin
            o_man_big    <= {man_big_q, 2'b00};
            o_man_small  <= sat_q ? '0 : shf_out;
            o_exp        <= exp_big_q;
            o_sign_big   <= sign_big_q;
            o_sign_small <= sign_small_q;
            o_swap       <= swap_q;
        end
    end

`ifdef FP_ALIGN_STICKY_EN
    logic [ALN_W-1:0] sticky_mask;
    logic             sticky_c;

    // Mask keeps exactly the low bits the shifter discards
    always_comb begin
        sticky_mask = ~({ALN_W{1'b1}} << shift_q);
        sticky_c    = sat_q ? (|man_small_q) : (|(shf_in & sticky_mask));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_sticky <= 1'b0;
        end else if (load_out) begin
            o_sticky <= sticky_c;
        end
    end
`else
    assign o_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_fp_align_ctrl.sv
// Scoreboard bench for fp_align_ctrl: directed alignment cases, back-pressure, mid-op reset, random pairs.
module tb_fp_align_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready_dut, out_valid, in_ready;
    logic [31:0] a, b;
    logic [25:0] man_big, man_small;
    logic [7:0]  expo;
    logic        sign_big, sign_small, sticky, swap;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [25:0] man_big;
        logic [25:0] man_small;
        logic [7:0]  expo;
        logic        sign_big;
        logic        sign_small;
        logic        sticky;
        logic        swap;
    } exp_res_t;

    exp_res_t sb_q[$];

    always #5 clk = ~clk;

    fp_align_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (in_valid),
        .o_ready      (out_ready_dut),
        .i_a          (a),
        .i_b          (b),
        .o_valid      (out_valid),
        .i_ready      (in_ready),
        .o_man_big    (man_big),
        .o_man_small  (man_small),
        .o_exp        (expo),
        .o_sign_big   (sign_big),
        .o_sign_small (sign_small),
        .o_sticky     (sticky),
        .o_swap       (swap)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference alignment computed with wide integer shifts
    function automatic exp_res_t model(input logic [31:0] op_a, input logic [31:0] op_b);
        exp_res_t    r;
        logic [7:0]  ea, eb;
        logic [23:0] ma, mb, ms;
        int          xa, xb, d;
        logic [63:0] x;
        logic        st;
        ea = op_a[30:23];
        eb = op_b[30:23];
        ma = {(ea != 8'd0), op_a[22:0]};
        mb = {(eb != 8'd0), op_b[22:0]};
        xa = (ea == 8'd0) ? 1 : int'(ea);
        xb = (eb == 8'd0) ? 1 : int'(eb);
        r.swap = ({eb, mb} > {ea, ma});
        if (r.swap) begin
            r.man_big    = {mb, 2'b00};
            r.expo       = 8'(xb);
            r.sign_big   = op_b[31];
            r.sign_small = op_a[31];
            ms           = ma;
            d            = xb - xa;
        end else begin
            r.man_big    = {ma, 2'b00};
            r.expo       = 8'(xa);
            r.sign_big   = op_a[31];
            r.sign_small = op_b[31];
            ms           = mb;
            d            = xa - xb;
        end
        x = 64'(ms) << 2;
        if (d > 31) begin
            r.man_small = 26'd0;
            st          = (ms != 24'd0);
        end else begin
            r.man_small = 26'(x >> d);
            st          = (((x >> d) << d) != x);
        end
`ifdef FP_ALIGN_STICKY_EN
        r.sticky = st;
`else
        r.sticky = 1'b0 & st;
`endif
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_out(input string tag, input exp_res_t e);
        check_eq({tag, "_man_big"},    32'(man_big),    32'(e.man_big));
        check_eq({tag, "_man_small"},  32'(man_small),  32'(e.man_small));
        check_eq({tag, "_exp"},        32'(expo),       32'(e.expo));
        check_eq({tag, "_sign_big"},   32'(sign_big),   32'(e.sign_big));
        check_eq({tag, "_sign_small"}, 32'(sign_small), 32'(e.sign_small));
        check_eq({tag, "_sticky"},     32'(sticky),     32'(e.sticky));
        check_eq({tag, "_swap"},       32'(swap),       32'(e.swap));
    endtask

    // Drive one pair for one cycle and check it shows up exactly 3 cycles after accept
    task automatic send(input logic [31:0] op_a, input logic [31:0] op_b);
        int lat;
        check_eq("ready_before_send", 32'(out_ready_dut), 32'd1);
        a        = op_a;
        b        = op_b;
        in_valid = 1'b1;
        sb_q.push_back(model(op_a, op_b));
        step();
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        lat      = 1;
        while (!out_valid && lat < 12) begin
            step();
            lat++;
        end
        check_eq("latency", 32'(lat), 32'd3);
    endtask

    // Hold back-pressure for 'hold' cycles, then complete the transfer
    task automatic drain(input int hold);
        exp_res_t e;
        if (sb_q.size() == 0) begin
            check_eq("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        compare_out("out", e);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a        = $urandom;
            b        = $urandom;
            step();
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_ready", 32'(out_ready_dut), 32'd0);
            compare_out("hold", e);
        end
        in_ready = 1'b1;
        step();
        in_ready = 1'b0;
        check_eq("post_valid", 32'(out_valid), 32'd0);
        check_eq("post_ready", 32'(out_ready_dut), 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_ready = 1'b0;
        a        = '0;
        b        = '0;
        step();
        step();
        rst = 1'b0;
        check_eq("rst_ready",     32'(out_ready_dut), 32'd1);
        check_eq("rst_valid",     32'(out_valid),     32'd0);
        check_eq("rst_man_big",   32'(man_big),       32'd0);
        check_eq("rst_man_small", 32'(man_small),     32'd0);
        check_eq("rst_exp",       32'(expo),          32'd0);
        step();

        send(32'h4000_0000, 32'h3F80_0000);
        check_eq("t1_man_small_const", 32'(man_small), 32'h100_0000);
        drain(0);
        send(32'h3F80_0000, 32'h4080_0000);
        drain(1);
        send(32'h4B80_0000, 32'h3F80_0001);
        check_eq("t3_man_small_const", 32'(man_small), 32'd2);
        drain(0);
        send(32'h7F00_0000, 32'h3F80_0000);
        check_eq("t4_exp_const", 32'(expo), 32'hFE);
        drain(0);
        send(32'h4000_0000, 32'h3F80_0000);
        drain(5);
        send(32'hC120_0000, 32'h4120_0000);
        drain(0);
        send(32'h0000_0003, 32'h0080_0001);
        drain(0);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 0) rb[30:23] = ra[30:23] - 8'($urandom_range(0, 40));
            send(ra, rb);
            drain(int'($urandom_range(0, 2)));
        end

        // Reset while in S_SHIFT
        send(32'h4B80_0000, 32'h3F80_0001);
        drain(0);
        check_eq("idle_ready", 32'(out_ready_dut), 32'd1);
        a        = 32'h4000_0000;
        b        = 32'h3F80_0000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mid_rst_valid",     32'(out_valid),     32'd0);
        check_eq("mid_rst_ready",     32'(out_ready_dut), 32'd1);
        check_eq("mid_rst_man_big",   32'(man_big),       32'd0);
        check_eq("mid_rst_man_small", 32'(man_small),     32'd0);
        check_eq("mid_rst_exp",       32'(expo),          32'd0);
        check_eq("mid_rst_swap",      32'(swap),          32'd0);
        check_eq("mid_rst_sticky",    32'(sticky),        32'd0);
        step();
        check_eq("mid_rst_stay_idle", 32'(out_valid), 32'd0);
        send(32'h3F80_0000, 32'h4080_0000);
        drain(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
